// File: rtl/operand_select_pkg.sv
// operand_select_pkg: prefix encodings and selection states shared by the operand selector
package operand_select_pkg;
    typedef enum logic [1:0] {
        PREFIX_NONE = 2'b00,
        PREFIX_FROM = 2'b01,
        PREFIX_TO   = 2'b10,
        PREFIX_WITH = 2'b11
    } prefix_kind_e;
    typedef enum logic [1:0] {
        SEL_DEFAULT,
        SEL_SELECTED,
        SEL_BOUND
    } sel_state_e;
endpackage

// File: rtl/mux_n_way.sv
// mux_n_way: combinational CHANNELS:1 WIDTH-bit multiplexer over a flat channel bus
module mux_n_way #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          y
);
    // the selector is always kept in range by the caller, so no default channel is needed
    always_comb y = data[sel*WIDTH +: WIDTH];
endmodule

// File: rtl/operand_select_mux.sv
// operand_select_mux: SuperFX FROM/TO/WITH operand selector; OPERAND_SELECT_REGOUT_EN registers selected_output
module operand_select_mux
    import operand_select_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_input,
    input  logic                      prefix_valid,
    input  logic [1:0]                prefix_kind,
    input  logic [SEL_W-1:0]          prefix_reg,
    input  logic                      instr_done,
    output logic [WIDTH-1:0]          selected_output,
    output logic [SEL_W-1:0]          source_sel,
    output logic [SEL_W-1:0]          dest_sel,
    output logic                      with_flag,
    output logic                      range_error
);
    sel_state_e        state, state_n;
    prefix_kind_e      kind;
    logic [SEL_W-1:0]  src_n, dst_n;
    logic              take, in_range, range_n;
    logic [WIDTH-1:0]  mux_out;
    // retire clears first, then an in-range prefix is layered on top of the cleared state
    always_comb begin
        kind     = prefix_kind_e'(prefix_kind);
        take     = prefix_valid && kind != PREFIX_NONE;
        in_range = 32'(prefix_reg) < CHANNELS;
        range_n  = take && !in_range;
        state_n  = instr_done ? SEL_DEFAULT : state;
        src_n    = instr_done ? '0 : source_sel;
        dst_n    = instr_done ? '0 : dest_sel;
        if (take && in_range) begin
            src_n   = (kind == PREFIX_FROM || kind == PREFIX_WITH) ? prefix_reg : src_n;
            dst_n   = (kind == PREFIX_TO   || kind == PREFIX_WITH) ? prefix_reg : dst_n;
            state_n = (kind == PREFIX_WITH || state_n == SEL_BOUND) ? SEL_BOUND : SEL_SELECTED;
        end
    end
    // selection state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEL_DEFAULT;
            source_sel  <= '0;
            dest_sel    <= '0;
            range_error <= 1'b0;
        end else begin
            state       <= state_n;
            source_sel  <= src_n;
            dest_sel    <= dst_n;
            range_error <= range_n;
        end
    end
    assign with_flag = state == SEL_BOUND;
    mux_n_way #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_mux (
        .data (data_input),
        .sel  (source_sel),
        .y    (mux_out)
    );
`ifdef OPERAND_SELECT_REGOUT_EN
    // registered operand output, one cycle behind source_sel and data_input
    always_ff @(posedge clk) begin
        if (reset) selected_output <= '0;
        else       selected_output <= mux_out;
    end
`else
    assign selected_output = mux_out;
`endif
endmodule

// File: tb/tb_operand_select_mux.sv
// tb_operand_select_mux: table-driven check of the operand selector at 16 and 12 channels
module tb_operand_select_mux;
`ifdef OPERAND_SELECT_REGOUT_EN
    localparam bit LAT = 1'b1;
`else
    localparam bit LAT = 1'b0;
`endif
    typedef struct {
        logic v; logic [1:0] k; logic [3:0] r; logic d;
        logic [3:0] s; logic [3:0] ds; logic w; logic re;
        logic [3:0] s12; logic re12;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1;
    logic [255:0] data16;
    logic [191:0] data12;
    logic pv = 1'b0, done = 1'b0;
    logic [1:0] pk = 2'b00;
    logic [3:0] pr = 4'd0;
    logic [15:0] out16, out12;
    logic [3:0] src16, dst16, src12, dst12;
    logic w16, w12, re16, re12;
    int checks = 0, failures = 0;
    vec_t tab[$];

    always #5 clk = ~clk;

    operand_select_mux #(.WIDTH(16), .CHANNELS(16)) dut16 (
        .clk(clk), .reset(reset), .data_input(data16), .prefix_valid(pv),
        .prefix_kind(pk), .prefix_reg(pr), .instr_done(done),
        .selected_output(out16), .source_sel(src16), .dest_sel(dst16),
        .with_flag(w16), .range_error(re16)
    );
    operand_select_mux #(.WIDTH(16), .CHANNELS(12)) dut12 (
        .clk(clk), .reset(reset), .data_input(data12), .prefix_valid(pv),
        .prefix_kind(pk), .prefix_reg(pr), .instr_done(done),
        .selected_output(out12), .source_sel(src12), .dest_sel(dst12),
        .with_flag(w12), .range_error(re12)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [1:0] k, input logic [3:0] r, input logic d,
                       input logic [3:0] s, input logic [3:0] ds, input logic w, input logic re,
                       input logic [3:0] s12, input logic re12x);
        vec_t t;
        t.v = v; t.k = k; t.r = r; t.d = d; t.s = s; t.ds = ds; t.w = w; t.re = re;
        t.s12 = s12; t.re12 = re12x;
        tab.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [1:0] k, input logic [3:0] r, input logic d);
        pv = v; pk = k; pr = r; done = d;
    endtask

    initial begin
        logic [3:0] prev16, prev12;
        for (int i = 0; i < 16; i++) data16[i*16 +: 16] = 16'h1000 + 16'(i);
        data12 = data16[191:0];
        //   v  kind   reg  done  src  dst  w  re  src12 re12
        add(0, 2'b00, 4'd0,  0, 4'd0,  4'd0,  0, 0, 4'd0,  0);
        add(0, 2'b00, 4'd0,  0, 4'd0,  4'd0,  0, 0, 4'd0,  0);
        add(0, 2'b00, 4'd0,  0, 4'd0,  4'd0,  0, 0, 4'd0,  0);
        add(1, 2'b01, 4'd5,  0, 4'd5,  4'd0,  0, 0, 4'd5,  0);
        add(0, 2'b00, 4'd0,  0, 4'd5,  4'd0,  0, 0, 4'd5,  0);
        add(0, 2'b00, 4'd0,  0, 4'd5,  4'd0,  0, 0, 4'd5,  0);
        add(0, 2'b00, 4'd0,  1, 4'd0,  4'd0,  0, 0, 4'd0,  0);
        add(1, 2'b11, 4'd9,  0, 4'd9,  4'd9,  1, 0, 4'd9,  0);
        add(1, 2'b10, 4'd3,  0, 4'd9,  4'd3,  1, 0, 4'd9,  0);
        add(1, 2'b01, 4'd4,  0, 4'd4,  4'd3,  1, 0, 4'd4,  0);
        add(0, 2'b00, 4'd0,  1, 4'd0,  4'd0,  0, 0, 4'd0,  0);
        add(1, 2'b01, 4'd4,  0, 4'd4,  4'd0,  0, 0, 4'd4,  0);
        add(1, 2'b01, 4'd7,  1, 4'd7,  4'd0,  0, 0, 4'd7,  0);
        add(1, 2'b00, 4'd5,  0, 4'd7,  4'd0,  0, 0, 4'd7,  0);
        add(1, 2'b10, 4'd6,  0, 4'd7,  4'd6,  0, 0, 4'd7,  0);
        add(1, 2'b01, 4'd13, 0, 4'd13, 4'd6,  0, 0, 4'd7,  1);
        add(0, 2'b00, 4'd0,  0, 4'd13, 4'd6,  0, 0, 4'd7,  0);
        add(1, 2'b10, 4'd15, 0, 4'd13, 4'd15, 0, 0, 4'd7,  1);
        add(0, 2'b00, 4'd0,  1, 4'd0,  4'd0,  0, 0, 4'd0,  0);
        add(1, 2'b11, 4'd12, 1, 4'd12, 4'd12, 1, 0, 4'd0,  1);
        add(0, 2'b00, 4'd0,  1, 4'd0,  4'd0,  0, 0, 4'd0,  0);

        drive(0, 2'b00, 4'd0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_src", 32'(src16), 0);
        chk("reset_dst", 32'(dst16), 0);
        chk("reset_with", 32'(w16), 0);
        chk("reset_rerr", 32'(re16), 0);
        chk("reset_out", 32'(out16), LAT ? 0 : 32'h1000);
        reset = 1'b0;
        prev16 = 4'd0;
        prev12 = 4'd0;
        foreach (tab[i]) begin
            drive(tab[i].v, tab[i].k, tab[i].r, tab[i].d);
            @(negedge clk);
            chk($sformatf("row%0d_src", i), 32'(src16), 32'(tab[i].s));
            chk($sformatf("row%0d_dst", i), 32'(dst16), 32'(tab[i].ds));
            chk($sformatf("row%0d_with", i), 32'(w16), 32'(tab[i].w));
            chk($sformatf("row%0d_rerr", i), 32'(re16), 32'(tab[i].re));
            chk($sformatf("row%0d_out", i), 32'(out16), 32'h1000 + 32'(LAT ? prev16 : tab[i].s));
            chk($sformatf("row%0d_src12", i), 32'(src12), 32'(tab[i].s12));
            chk($sformatf("row%0d_rerr12", i), 32'(re12), 32'(tab[i].re12));
            chk($sformatf("row%0d_out12", i), 32'(out12), 32'h1000 + 32'(LAT ? prev12 : tab[i].s12));
            prev16 = tab[i].s;
            prev12 = tab[i].s12;
        end

        drive(1, 2'b10, 4'd6, 0);
        @(negedge clk);
        chk("to6_dst", 32'(dst16), 6);
        reset = 1'b1;
        drive(1, 2'b01, 4'd9, 0);
        @(negedge clk);
        chk("midreset_src", 32'(src16), 0);
        chk("midreset_dst", 32'(dst16), 0);
        chk("midreset_with", 32'(w16), 0);
        chk("midreset_rerr", 32'(re16), 0);
        chk("midreset_out", 32'(out16), LAT ? 0 : 32'h1000);
        reset = 1'b0;
        drive(0, 2'b00, 4'd0, 0);
        @(negedge clk);
        chk("postreset_dst", 32'(dst16), 0);
        chk("postreset_out", 32'(out16), 32'h1000);

        data16[0 +: 16] = 16'hbeef;
        data12 = data16[191:0];
        if (LAT) begin
            @(posedge clk); #1;
            chk("data_track_out", 32'(out16), 32'hbeef);
        end else begin
            #1;
            chk("data_track_out", 32'(out16), 32'hbeef);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
